// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared convolution engine types and defaults
package conv_pkg;

    localparam int CONV_CORES = 24;
    localparam int CONV_UNITS = 8;
    localparam int WORD_WIDTH = 25;

    typedef logic [WORD_WIDTH-1:0] out_word_t;
    typedef out_word_t [CONV_UNITS-1:0] out_beat_t;

    // Reader occupancy: number of filled slots in the output buffer
    typedef enum logic [1:0] {
        RD_EMPTY = 2'd0,
        RD_ONE   = 2'd1,
        RD_FULL  = 2'd2
    } rd_state_t;

endpackage

// File: rtl/axis_output_pipe.sv
// rtl/axis_output_pipe.sv - two-slot buffer serializing engine beats onto AXI-Stream
module axis_output_pipe #(
    parameter int CONV_CORES  = conv_pkg::CONV_CORES,
    parameter int CONV_UNITS  = conv_pkg::CONV_UNITS,
    parameter int WORD_WIDTH  = conv_pkg::WORD_WIDTH,
    parameter int TUSER_WIDTH = 4
) (
    input  logic                                                  aclk,
    input  logic                                                  areset,
    input  logic                                                  s_valid,
    output logic                                                  s_ready,
    input  logic [CONV_CORES-1:0][CONV_UNITS-1:0][WORD_WIDTH-1:0] s_data,
    input  logic                                                  s_last,
    input  logic [TUSER_WIDTH-1:0]                                s_user,
    output logic                                                  m_axis_tvalid,
    input  logic                                                  m_axis_tready,
    output logic [CONV_UNITS-1:0][WORD_WIDTH-1:0]                 m_axis_tdata,
    output logic                                                  m_axis_tlast,
    output logic [TUSER_WIDTH-1:0]                                m_axis_tuser,
    output logic                                                  overflow
);

    localparam int IDX_W = (CONV_CORES > 1) ? $clog2(CONV_CORES) : 1;
    localparam logic [IDX_W-1:0] LAST_CORE = IDX_W'(CONV_CORES - 1);

    conv_pkg::rd_state_t state;
    logic                wr_sel;
    logic                rd_sel;
    logic [IDX_W-1:0]    core_idx;
    logic                ovf_q;

    logic [1:0][CONV_CORES-1:0][CONV_UNITS-1:0][WORD_WIDTH-1:0] slot_data;
    logic [1:0]                                                 slot_last;
    logic [1:0][TUSER_WIDTH-1:0]                                slot_user;

    logic wr_en;
    logic rd_hs;
    logic free_slot;

    // Ready depends only on registered occupancy, so a slot freed this cycle is not reusable until the next
    assign s_ready       = (state != conv_pkg::RD_FULL);
    assign m_axis_tvalid = (state != conv_pkg::RD_EMPTY);
    assign overflow      = ovf_q;

    assign wr_en     = s_valid & s_ready;
    assign rd_hs     = m_axis_tvalid & m_axis_tready;
    assign free_slot = rd_hs & (core_idx == LAST_CORE);

    // Output mux: current core of the slot being drained
    always_comb begin
        m_axis_tdata = slot_data[rd_sel][core_idx];
        m_axis_tlast = slot_last[rd_sel] & (core_idx == LAST_CORE);
        m_axis_tuser = slot_user[rd_sel];
    end

    // Slot storage, pointers, occupancy and sticky overflow
    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= conv_pkg::RD_EMPTY;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            core_idx  <= '0;
            ovf_q     <= 1'b0;
            slot_last <= '0;
        end else begin
            if (wr_en) begin
                slot_data[wr_sel] <= s_data;
                slot_last[wr_sel] <= s_last;
                slot_user[wr_sel] <= s_user;
                wr_sel            <= ~wr_sel;
            end

            if (s_valid && !s_ready) begin
                ovf_q <= 1'b1;
            end

            if (rd_hs) begin
                if (core_idx == LAST_CORE) begin
                    core_idx <= '0;
                    rd_sel   <= ~rd_sel;
                end else begin
                    core_idx <= core_idx + 1'b1;
                end
            end

            case ({wr_en, free_slot})
                2'b10: state <= (state == conv_pkg::RD_EMPTY) ? conv_pkg::RD_ONE
                                                              : conv_pkg::RD_FULL;
                2'b01: state <= (state == conv_pkg::RD_FULL)  ? conv_pkg::RD_ONE
                                                              : conv_pkg::RD_EMPTY;
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_output_pipe.sv
// tb/tb_axis_output_pipe.sv - scoreboard bench for axis_output_pipe
module tb_axis_output_pipe;

    localparam int CC = 4;
    localparam int CU = 2;
    localparam int WW = 25;
    localparam int UW = 4;

    typedef logic [CC-1:0][CU-1:0][WW-1:0] in_beat_t;
    typedef logic [CU-1:0][WW-1:0]         out_beat_t;

    typedef struct {
        out_beat_t       data;
        logic            last;
        logic [UW-1:0]   user;
        bit              fin;
    } exp_t;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    in_beat_t      s_data = '0;
    logic          s_last = 1'b0;
    logic [UW-1:0] s_user = '0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    out_beat_t     m_axis_tdata;
    logic          m_axis_tlast;
    logic [UW-1:0] m_axis_tuser;
    logic          overflow;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   accepted = 0;
    int   freed = 0;
    int   tlast_cnt = 0;
    bit   exp_ovf = 0;

    axis_output_pipe #(
        .CONV_CORES (CC),
        .CONV_UNITS (CU),
        .WORD_WIDTH (WW),
        .TUSER_WIDTH(UW)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_user       (s_user),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .overflow     (overflow)
    );

    always #5 aclk = ~aclk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented beat against the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            #1;
            if (areset) continue;
            checks++;
            if (m_axis_tvalid !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL tvalid: got %b expected %b at %0t",
                         m_axis_tvalid, exp_q.size() != 0, $time);
            end else if (m_axis_tvalid) begin
                e = exp_q[0];
                checks++;
                if (m_axis_tdata !== e.data || m_axis_tlast !== e.last || m_axis_tuser !== e.user) begin
                    errors++;
                    $display("FAIL beat: got data=%h last=%b user=%h expected data=%h last=%b user=%h at %0t",
                             m_axis_tdata, m_axis_tlast, m_axis_tuser, e.data, e.last, e.user, $time);
                end
                if (m_axis_tready) begin
                    void'(exp_q.pop_front());
                    if (e.fin) freed++;
                    if (m_axis_tlast) tlast_cnt++;
                end
            end
        end
    end

    // One engine cycle: present inputs, predict acceptance, queue the expected burst
    task automatic step(input logic v, input in_beat_t d, input logic l,
                        input logic [UW-1:0] u, input logic rdy);
        bit acc;
        s_valid = v;
        s_data = d;
        s_last = l;
        s_user = u;
        m_axis_tready = rdy;
        @(negedge aclk);
        check_bit("s_ready", s_ready, (accepted - freed) < 2);
        check_bit("overflow", overflow, exp_ovf);
        acc = v && ((accepted - freed) < 2);
        if (v && !acc) exp_ovf = 1;
        @(posedge aclk);
        #1;
        if (acc) begin
            for (int c = 0; c < CC; c++) begin
                exp_t e;
                e.data = d[c];
                e.last = l && (c == CC - 1);
                e.user = u;
                e.fin  = (c == CC - 1);
                exp_q.push_back(e);
            end
            accepted++;
        end
        s_valid = 1'b0;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, 1'b0, '0, rdy);
    endtask

    task automatic drain(input int max_cycles, input bit random_rdy);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            idle(random_rdy ? logic'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats left, expected 0", exp_q.size());
        end
        idle(1'b1);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        s_valid = 1'b0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        exp_q.delete();
        accepted = 0;
        freed = 0;
        exp_ovf = 0;
        @(negedge aclk);
        check_bit("rst_tvalid", m_axis_tvalid, 1'b0);
        check_bit("rst_s_ready", s_ready, 1'b1);
        check_bit("rst_overflow", overflow, 1'b0);
        check_bit("rst_tlast", m_axis_tlast, 1'b0);
        @(posedge aclk);
        #1;
    endtask

    function automatic in_beat_t pattern(input int base);
        in_beat_t d;
        for (int c = 0; c < CC; c++)
            for (int u = 0; u < CU; u++)
                d[c][u] = WW'(base + 10 * c + u);
        return d;
    endfunction

    function automatic in_beat_t rand_beat();
        in_beat_t d;
        for (int c = 0; c < CC; c++)
            for (int u = 0; u < CU; u++)
                d[c][u] = WW'($urandom);
        return d;
    endfunction

    initial begin
        int sent;
        int n;
        int snap;
        logic v;

        repeat (2) @(posedge aclk);
        #1;
        do_reset();

        // Single beat, tready high
        step(1'b1, pattern(0), 1'b1, 4'd5, 1'b1);
        drain(20, 0);

        // Fill with tready low, third beat overflows and is dropped
        step(1'b1, pattern(100), 1'b0, 4'd1, 1'b0);
        step(1'b1, pattern(200), 1'b1, 4'd2, 1'b0);
        step(1'b1, pattern(300), 1'b1, 4'd3, 1'b0);
        idle(1'b0);
        drain(40, 0);

        // Write in the same cycle slot A frees: rejected
        do_reset();
        step(1'b1, pattern(400), 1'b0, 4'd4, 1'b0);
        step(1'b1, pattern(500), 1'b1, 4'd6, 1'b0);
        repeat (3) idle(1'b1);
        step(1'b1, pattern(600), 1'b1, 4'd7, 1'b1);
        idle(1'b1);
        drain(40, 0);

        // Write one cycle after slot A frees: accepted, buffer full again
        do_reset();
        step(1'b1, pattern(700), 1'b0, 4'd8, 1'b0);
        step(1'b1, pattern(800), 1'b1, 4'd9, 1'b0);
        repeat (4) idle(1'b1);
        step(1'b1, pattern(900), 1'b1, 4'd10, 1'b0);
        idle(1'b0);
        drain(40, 0);

        // Random backpressure over 20 bursts
        do_reset();
        snap = tlast_cnt;
        sent = 0;
        n = 0;
        while (sent < 20 && n < 3000) begin
            v = ((accepted - freed) < 2) && ($urandom_range(0, 1) == 1);
            step(v, rand_beat(), 1'b1, UW'($urandom), logic'($urandom_range(0, 1)));
            if (v) sent++;
            n++;
        end
        checks++;
        if (sent != 20) begin
            errors++;
            $display("FAIL random_send: sent %0d bursts, expected 20", sent);
        end
        drain(2000, 1);
        checks++;
        if (tlast_cnt - snap != 20) begin
            errors++;
            $display("FAIL tlast_count: got %0d expected 20", tlast_cnt - snap);
        end

        // Reset mid-burst after two of four beats, then a fresh burst from core 0
        step(1'b1, pattern(1000), 1'b1, 4'd11, 1'b1);
        idle(1'b1);
        idle(1'b1);
        do_reset();
        step(1'b1, pattern(2000), 1'b1, 4'd12, 1'b1);
        drain(20, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
